// File: rtl/jt51_wr_sched_if.sv
// jt51_wr_sched_if: bundles the requester handshakes, the jt51 CPU-port pins
// and the status signals of the jt51 write scheduler.
//   req0/req1, addr0/addr1, data0/data1 : requester write requests
//   ack0/ack1                           : one-cycle completion pulses
//   ym_cs_n, ym_wr_n, ym_a0, ym_din     : driven to the jt51 CPU port
//   ym_dout                             : read back from the jt51 (bit 7 = busy)
//   sched_busy, owner, timeout_err      : scheduler status
//   err_clr                             : clears timeout_err
// slave  : the scheduler side.
// master : the environment (requesters plus the chip).
interface jt51_wr_sched_if;
  logic       req0;
  logic       req1;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic       ym_a0;
  logic [7:0] ym_din;
  logic [7:0] ym_dout;
  logic       sched_busy;
  logic       owner;
  logic       err_clr;
  logic       timeout_err;

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1, ym_dout, err_clr,
    output ack0, ack1, ym_cs_n, ym_wr_n, ym_a0, ym_din, sched_busy, owner, timeout_err
  );

  modport master (
    output req0, req1, addr0, addr1, data0, data1, ym_dout, err_clr,
    input  ack0, ack1, ym_cs_n, ym_wr_n, ym_a0, ym_din, sched_busy, owner, timeout_err
  );
endinterface

// File: rtl/jt51_wr_sched.sv
// jt51_wr_sched: round-robin write scheduler for the jt51 CPU port.
// Each granted (register, value) pair becomes an address write (a0=0) and a
// data write (a0=1), each followed by a guarded busy poll on ym_dout[7].
// The address write is skipped when the register number matches the last
// address successfully written.
// Ports:
//   clk : main clock (jt51 clk)
//   rst : synchronous active-high reset
//   bus : jt51_wr_sched_if.slave (requesters, jt51 pins, status)
// Parameters:
//   WR_LEN  : cycles cs_n/wr_n are held low per write (>=1)
//   GUARD   : wait cycles before busy is first sampled (>=1)
//   TIMEOUT : wait cycles, guard included, before a write is abandoned
module jt51_wr_sched #(
  parameter int WR_LEN  = 2,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  jt51_wr_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A_WR   = 3'd1,
    S_A_WAIT = 3'd2,
    S_D_WR   = 3'd3,
    S_D_WAIT = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [7:0] WR_LAST = 8'(WR_LEN - 1);
  localparam logic [7:0] GUARD_C = 8'(GUARD);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       owner_q, owner_d;
  logic       mask_q, mask_d;
  logic       cvld_q, cvld_d;
  logic [7:0] caddr_q, caddr_d;
  logic       err_q, err_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a0_q, a0_d;
  logic [7:0] din_q, din_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q, busy_d;

  logic req0_s, req1_s, sel_s, poll_s, err_set_s, wr_s;

  // Next-state, arbitration, address cache and registered-output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    owner_d   = owner_q;
    mask_d    = 1'b0;
    cvld_d    = cvld_q;
    caddr_d   = caddr_q;
    err_set_s = 1'b0;
    sel_s     = 1'b0;
    // The channel just served sits out the single IDLE cycle after DONE.
    req0_s    = bus.req0 & ~(mask_q & ~owner_q);
    req1_s    = bus.req1 & ~(mask_q & owner_q);
    // Busy is ignored until the guard has elapsed.
    poll_s    = (cnt_q >= GUARD_C) & ~bus.ym_dout[7];

    case (state_q)
      S_IDLE: begin
        if (req0_s | req1_s) begin
          sel_s   = (req0_s & req1_s) ? ~owner_q : req1_s;
          owner_d = sel_s;
          addr_d  = sel_s ? bus.addr1 : bus.addr0;
          data_d  = sel_s ? bus.data1 : bus.data0;
          if (cvld_q && (caddr_q == addr_d)) begin
            state_d = S_D_WR;
          end else begin
            state_d = S_A_WR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_A_WR: begin
        if (cnt_q == WR_LAST) begin
          state_d = S_A_WAIT;
        end else begin
          state_d = S_A_WR;
        end
      end
      S_A_WAIT: begin
        if (poll_s) begin
          state_d = S_D_WR;
          cvld_d  = 1'b1;
          caddr_d = addr_q;
        end else if (cnt_q == TO_LAST) begin
          // Abandon the whole transaction; the data phase is skipped.
          state_d   = S_DONE;
          err_set_s = 1'b1;
          cvld_d    = 1'b0;
        end else begin
          state_d = S_A_WAIT;
        end
      end
      S_D_WR: begin
        if (cnt_q == WR_LAST) begin
          state_d = S_D_WAIT;
        end else begin
          state_d = S_D_WR;
        end
      end
      S_D_WAIT: begin
        if (poll_s) begin
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          err_set_s = 1'b1;
          cvld_d    = 1'b0;
        end else begin
          state_d = S_D_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mask_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Phase counter restarts on every state change and saturates.
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are decoded from the next state so the registered pins line
    // up with the state they belong to.
    wr_s   = (state_d == S_A_WR) || (state_d == S_D_WR);
    cs_n_d = ~wr_s;
    wr_n_d = ~wr_s;
    if (state_d == S_A_WR) begin
      a0_d  = 1'b0;
      din_d = addr_d;
    end else if (state_d == S_D_WR) begin
      a0_d  = 1'b1;
      din_d = data_d;
    end else begin
      a0_d  = a0_q;
      din_d = din_q;
    end
    ack0_d = (state_d == S_DONE) & ~owner_d;
    ack1_d = (state_d == S_DONE) & owner_d;
    busy_d = (state_d != S_IDLE);
    // A timeout in the same cycle as err_clr keeps the flag set.
    err_d  = err_set_s | (err_q & ~bus.err_clr);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      owner_q <= 1'b1;
      mask_q  <= 1'b0;
      cvld_q  <= 1'b0;
      caddr_q <= 8'd0;
      err_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a0_q    <= 1'b0;
      din_q   <= 8'd0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      cvld_q  <= cvld_d;
      caddr_q <= caddr_d;
      err_q   <= err_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      a0_q    <= a0_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.ym_cs_n     = cs_n_q;
  assign bus.ym_wr_n     = wr_n_q;
  assign bus.ym_a0       = a0_q;
  assign bus.ym_din      = din_q;
  assign bus.sched_busy  = busy_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = err_q;

endmodule
